pipe_scoreboard: RTL

PIPE_SCOREBOARD -- requirements
Module: pipe_scoreboard

---
 rtl/pipe_scoreboard.sv | 86 ++++++++
 1 files changed

// File: rtl/pipe_scoreboard.sv
// Issue-stage register scoreboard: one write-latency down-counter per architectural
// register, with RAW/WAW hazard detection and an optional bypass-readiness window.
module pipe_scoreboard #(
  parameter int REG_AW = 4,
  parameter int NRD    = 2,
  parameter int LAT_W  = 3,
  parameter int FWD_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic                  issue_we,
  input  logic [REG_AW-1:0]     issue_rd,
  input  logic [LAT_W-1:0]      issue_lat,
  input  logic [NRD*REG_AW-1:0] src_addr,
  input  logic [NRD-1:0]        src_used,
  input  logic                  flush,
  output logic                  stall,
  output logic                  issue_accept,
  output logic [NRD-1:0]        fwd_hit,
  output logic [REG_AW:0]       busy_count
);

  localparam int NREG = 1 << REG_AW;

  logic [LAT_W-1:0]  cnt_q [NREG];
  logic [LAT_W-1:0]  cnt_d [NREG];
  logic [REG_AW:0]   busy_count_q;
  logic [REG_AW:0]   busy_count_d;

  logic [LAT_W-1:0]  src_cnt [NRD];
  logic [NRD-1:0]    port_ok;
  logic [NRD-1:0]    fwd_raw;
  logic              waw_hazard;
  logic              load_en;

  function automatic logic [LAT_W-1:0] sat_dec(input logic [LAT_W-1:0] v);
    sat_dec = (v != '0) ? v - LAT_W'(1) : '0;
  endfunction

  function automatic logic [REG_AW:0] count_busy(input logic [LAT_W-1:0] c [NREG]);
    count_busy = '0;
    for (int r = 0; r < NREG; r++) begin
      if (c[r] != '0) count_busy = count_busy + (REG_AW+1)'(1);
    end
  endfunction

  // Hazard evaluation from current (pre-update) counters
  always_comb begin
    port_ok = '0;
    fwd_raw = '0;
    for (int k = 0; k < NRD; k++) begin
      src_cnt[k] = cnt_q[src_addr[k*REG_AW +: REG_AW]];
      fwd_raw[k] = src_used[k] && (FWD_EN != 0) && (src_cnt[k] == LAT_W'(1));
      port_ok[k] = !src_used[k] || (src_cnt[k] == '0) || fwd_raw[k];
    end
    waw_hazard   = issue_we && (cnt_q[issue_rd] > issue_lat);
    // Outputs are forced quiet while reset is held; accept still reflects the cleared state
    stall        = reset && issue_valid && !flush && (!(&port_ok) || waw_hazard);
    fwd_hit      = reset ? fwd_raw : '0;
    issue_accept = issue_valid && !flush && !stall;
    load_en      = issue_accept && issue_we && (issue_lat != '0);
  end

  // Next-state counters: decrement everywhere, a new load wins for its register
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = sat_dec(cnt_q[r]);
      if (load_en && (issue_rd == REG_AW'(r))) cnt_d[r] = issue_lat;
    end
    busy_count_d = count_busy(cnt_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
      busy_count_q <= '0;
    end else begin
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

endmodule
